grad_update_sequencer: RTL and testbench
========================================

# grad_update_sequencer

Sequences a stochastic-gradient-descent weight update across a bank of `NUM_WEIGHTS` Q-format weights and their gradient registers. On a `start` pulse it walks the index space in order. For each index it:
- reads the gradient and the weight,
- computes `w - lr*g` with saturation,
- writes the new weight back,
- clears the gradient.

It sits between the training controller and the weight/gradient storage, and is the only writer of weights during an update pass.

## Interface
Parameters:
- `FIXED_BITS`, 8, integer bits of the Q format
- `FRACTIONAL_BITS`, 8, fractional bits; `W = FIXED_BITS + FRACTIONAL_BITS`
- `NUM_WEIGHTS`, 16, number of weight/gradient pairs (≥1)
- `ADDR_W`, `$clog2(NUM_WEIGHTS)` (min 1), index width

Ports:
- `clk`  in  1  clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a pass; honoured only in IDLE
- `abort`  in  1  stop the pass early
- `lr`  in  W  signed learning rate, latched on accepted `start`
- `clip_limit`  in  W  positive gradient clamp (present only with `GRAD_CLIP_EN`)
- `busy`  out  1  high in READ/MUL/WRITE
- `done`  out  1  one-cycle pulse after the final write
- `rd_en`  out  1  read strobe to both weight and gradient storage
- `rd_addr`  out  ADDR_W  read index
- `grad_rd_data`  in  W  gradient, valid the cycle after `rd_en`
- `w_rd_data`  in  W  weight, valid the cycle after `rd_en`
- `w_wr_en`  out  1  weight write strobe
- `grad_clr_en`  out  1  gradient clear strobe (same cycle as `w_wr_en`)
- `wr_addr`  out  ADDR_W  write/clear index
- `w_wr_data`  out  W  updated weight

## Operation
- FSM states: IDLE, READ, MUL, WRITE, DONE.
- IDLE → READ on `start`. Latch `lr`; set index = 0.
- READ: assert `rd_en` with `rd_addr` = index. Next state is MUL.
- MUL: capture `grad_rd_data` and `w_rd_data`.
  - With `GRAD_CLIP_EN`, clamp the gradient first.
  - Register `prod = (g*lr) >>> FRACTIONAL_BITS`. The product is full 2W-bit signed; the shift is arithmetic (truncation toward −∞).
  - Next state is WRITE.
- WRITE: compute `w - prod` at W+1 bits.
  - Saturate to [−2^(W−1), 2^(W−1)−1].
  - Assert `w_wr_en` and `grad_clr_en` with `wr_addr` = index.
  - If index = `NUM_WEIGHTS`−1, go to DONE; otherwise increment index and go to READ.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; `lr` changes mid-pass have no effect.
- `abort` in READ or MUL: go to IDLE next cycle. No write for the current index, no `done`.
- `abort` in WRITE: the current write/clear completes, then IDLE. No `done`.
- `abort` in DONE or IDLE: no effect.
- `abort` and `start` together in IDLE: `start` wins.
- Reset, including mid-pass: state IDLE, index 0, latched `lr` 0. No partial write is issued afterward.

## Timing
- Reset values: `busy` 0, `done` 0, `rd_en` 0, `w_wr_en` 0, `grad_clr_en` 0, `rd_addr` 0, `wr_addr` 0, `w_wr_data` 0.
- All outputs are registered or decoded from registered state; nothing combinational from inputs to outputs.
- Pass timing, with `start` sampled at edge 0:
  - READ for index i occurs in cycle 3i+1.
  - WRITE for index i occurs in cycle 3i+3.
  - `done` is high in cycle 3·NUM_WEIGHTS+1.
  - IDLE resumes at 3·NUM_WEIGHTS+2.
- Throughput: 3 cycles per weight, no overlap between indices.
- Storage contract: 1-cycle read latency; write-before-read is not required, since an index is never read after its own write in the same pass.

## Configuration
- `GRAD_CLIP_EN` defined:
  - `clip_limit` port exists.
  - The gradient is clamped to [−`clip_limit`, +`clip_limit`] before the multiply.
  - `clip_limit` of 0 forces a zero update.
- Undefined: the port is omitted and the gradient is used unmodified.

## Structure
- Shared package `q_format_pkg`:
  - Q-format width constants and the signed Q typedef
  - saturation min/max constants
  - FSM state enum
- Sub-module `q_mul_sat`: signed Q multiply with arithmetic shift and saturating subtract helper. It is reused by other training blocks.

## Test plan
All values Q8.8.
- Basic update, `NUM_WEIGHTS`=1: `lr`=0x0080, g=0x0200, w=0x0100 → `w_wr_data`=0x0000 in cycle 3, `grad_clr_en`=1 in cycle 3, `done` in cycle 4.
- Positive saturation: `lr`=0x0100, g=0xFF00, w=0x7F00 → `w_wr_data`=0x7FFF.
- Truncation toward −∞: `lr`=0x0080, g=0xFFFF, w=0x0000 → `w_wr_data`=0x0001.
- Clip, with `clip_limit`=0x0100, `lr`=0x0100, g=0x0400, w=0x0200:
  - `GRAD_CLIP_EN` defined → `w_wr_data`=0x0100.
  - Undefined → `w_wr_data`=0xFE00.
- Full pass, `NUM_WEIGHTS`=16:
  - `wr_addr` goes 0..15 in cycles 3,6,…,48; `done` in cycle 49.
  - A second `start` at cycle 10 is ignored.
- Abort and reset:
  - `abort` during MUL of index 5 → no write to 5, `busy` low next cycle, no `done`.
  - `rst` during WRITE of index 2 → all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/q_format_pkg.sv
// Shared Q-format constants, signed Q typedef and the update-sequencer state enum.
// Default format is Q8.8; blocks may override widths through their own parameters.
package q_format_pkg;

    localparam int Q_FIXED_BITS = 8;
    localparam int Q_FRAC_BITS  = 8;
    localparam int Q_W          = Q_FIXED_BITS + Q_FRAC_BITS;

    typedef logic signed [Q_W-1:0] q_t;

    localparam q_t Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam q_t Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MUL   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/q_mul_sat.sv
// Signed Q multiply with arithmetic rescale (floor), plus a saturating subtract
// that clamps sub_a - sub_b to the W-bit signed range.
module q_mul_sat #(
    parameter int FIXED_BITS      = 8,
    parameter int FRACTIONAL_BITS = 8,
    localparam int W = FIXED_BITS + FRACTIONAL_BITS,
    localparam int P = 2*W - FRACTIONAL_BITS
) (
    input  logic signed [W-1:0] mul_a,
    input  logic signed [W-1:0] mul_b,
    output logic signed [P-1:0] prod,
    input  logic signed [W-1:0] sub_a,
    input  logic signed [P-1:0] sub_b,
    output logic signed [W-1:0] diff
);

    localparam logic signed [P:0] SAT_MAX = {{(P-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [P:0] SAT_MIN = {{(P-W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W-1:0] full;
    logic signed [P:0]     a_x;
    logic signed [P:0]     b_x;
    logic signed [P:0]     d;

    assign full = mul_a * mul_b;
    assign prod = P'(full >>> FRACTIONAL_BITS);

    // Product keeps its integer growth, so the difference is formed wide enough
    // that an oversized product saturates rather than wrapping.
    assign a_x = (P+1)'(sub_a);
    assign b_x = (P+1)'(sub_b);
    assign d   = a_x - b_x;

    always_comb begin
        diff = d[W-1:0];
        if (d > SAT_MAX)
            diff = SAT_MAX[W-1:0];
        else if (d < SAT_MIN)
            diff = SAT_MIN[W-1:0];
    end

endmodule

// File: rtl/grad_update_sequencer.sv
// SGD weight-update sequencer: per index READ -> MUL -> WRITE, w <= sat(w - lr*g).
// Optional gradient clamp enabled by defining GRAD_CLIP_EN (adds clip_limit port).
module grad_update_sequencer
    import q_format_pkg::*;
#(
    parameter int FIXED_BITS      = Q_FIXED_BITS,
    parameter int FRACTIONAL_BITS = Q_FRAC_BITS,
    parameter int NUM_WEIGHTS     = 16,
    parameter int ADDR_W          = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
    localparam int W = FIXED_BITS + FRACTIONAL_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic signed [W-1:0] lr,
`ifdef GRAD_CLIP_EN
    input  logic signed [W-1:0] clip_limit,
`endif
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic signed [W-1:0] grad_rd_data,
    input  logic signed [W-1:0] w_rd_data,
    output logic                w_wr_en,
    output logic                grad_clr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic signed [W-1:0] w_wr_data
);

    localparam int P = 2*W - FRACTIONAL_BITS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic signed [W-1:0] lr_q;
    logic signed [W-1:0] w_q;
    logic signed [P-1:0] prod_q;
    logic signed [P-1:0] prod_c;
    logic signed [W-1:0] diff_c;
    logic signed [W-1:0] g_eff;

`ifdef GRAD_CLIP_EN
    always_comb begin
        g_eff = grad_rd_data;
        if (grad_rd_data > clip_limit)
            g_eff = clip_limit;
        else if (grad_rd_data < -clip_limit)
            g_eff = -clip_limit;
    end
`else
    assign g_eff = grad_rd_data;
`endif

    q_mul_sat #(
        .FIXED_BITS      (FIXED_BITS),
        .FRACTIONAL_BITS (FRACTIONAL_BITS)
    ) u_mul_sat (
        .mul_a (g_eff),
        .mul_b (lr_q),
        .prod  (prod_c),
        .sub_a (w_q),
        .sub_b (prod_q),
        .diff  (diff_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  state_d = abort ? ST_IDLE : ST_MUL;
            ST_MUL:   state_d = abort ? ST_IDLE : ST_WRITE;
            ST_WRITE: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (idx_q == LAST_IDX)
                    state_d = ST_DONE;
                else
                    state_d = ST_READ;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lr_q    <= '0;
            w_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                lr_q  <= lr;
                idx_q <= '0;
            end
            if (state_q == ST_MUL) begin
                w_q    <= w_rd_data;
                prod_q <= prod_c;
            end
            if (state_q == ST_WRITE && state_d == ST_READ)
                idx_q <= idx_q + ADDR_W'(1);
            else if (state_q != ST_IDLE && state_d == ST_IDLE)
                idx_q <= '0;
        end
    end

    // Everything below decodes registered state only.
    assign busy        = (state_q == ST_READ) || (state_q == ST_MUL) || (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign rd_en       = (state_q == ST_READ);
    assign rd_addr     = idx_q;
    assign w_wr_en     = (state_q == ST_WRITE);
    assign grad_clr_en = (state_q == ST_WRITE);
    assign wr_addr     = idx_q;
    assign w_wr_data   = w_wr_en ? diff_c : '0;

endmodule

// File: tb/tb_grad_update_sequencer.sv
// Self-checking bench: Q8.8, a 16-weight instance against a storage model and an
// arithmetic reference, plus a single-weight instance for the directed value cases.
module tb_grad_update_sequencer;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic                start = 1'b0, abort = 1'b0;
    logic signed [W-1:0] lr = '0, clip_limit = '0;
    logic                busy, done, rd_en, w_wr_en, grad_clr_en;
    logic [AW-1:0]       rd_addr, wr_addr;
    logic signed [W-1:0] grad_rd_data, w_rd_data, w_wr_data;

    logic                start1 = 1'b0, abort1 = 1'b0;
    logic signed [W-1:0] lr1 = '0, g1 = '0, w1 = '0;
    logic                busy1, done1, rd_en1, w_wr_en1, grad_clr_en1;
    logic [0:0]          rd_addr1, wr_addr1;
    logic signed [W-1:0] w_wr_data1;

    grad_update_sequencer #(.NUM_WEIGHTS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lr(lr),
`ifdef GRAD_CLIP_EN
        .clip_limit(clip_limit),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .grad_rd_data(grad_rd_data), .w_rd_data(w_rd_data),
        .w_wr_en(w_wr_en), .grad_clr_en(grad_clr_en), .wr_addr(wr_addr),
        .w_wr_data(w_wr_data)
    );

    grad_update_sequencer #(.NUM_WEIGHTS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .lr(lr1),
`ifdef GRAD_CLIP_EN
        .clip_limit(clip_limit),
`endif
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .grad_rd_data(g1), .w_rd_data(w1),
        .w_wr_en(w_wr_en1), .grad_clr_en(grad_clr_en1), .wr_addr(wr_addr1),
        .w_wr_data(w_wr_data1)
    );

    // Storage behind the 16-weight instance: 1-cycle read, write/clear at the edge.
    logic [W-1:0] init_w [N];
    logic [W-1:0] init_g [N];
    logic [W-1:0] mem_w  [N];
    logic [W-1:0] mem_g  [N];
    logic         load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < N; k++) begin
                mem_w[k] <= init_w[k];
                mem_g[k] <= init_g[k];
            end
        end else begin
            if (rd_en) begin
                grad_rd_data <= mem_g[rd_addr];
                w_rd_data    <= mem_w[rd_addr];
            end
            if (w_wr_en)     mem_w[wr_addr] <= w_wr_data;
            if (grad_clr_en) mem_g[wr_addr] <= '0;
        end
    end

    // w - floor(g*lr / 256), clamped to the 16-bit signed range.
    function automatic logic [15:0] model_upd(input logic [15:0] wv, input logic [15:0] gv,
                                              input logic [15:0] lv, input logic [15:0] cv);
        longint gi, wi, li, ci, p, q, d;
        gi = longint'($signed(gv));
        wi = longint'($signed(wv));
        li = longint'($signed(lv));
        ci = longint'($signed(cv));
`ifdef GRAD_CLIP_EN
        if (gi > ci)  gi = ci;
        if (gi < -ci) gi = -ci;
`else
        if (ci > 0) gi = gi + 0;
`endif
        p = gi * li;
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        d = wi - q;
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return d[15:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, w_wr_en, grad_clr_en, rd_addr, wr_addr, w_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset16 outputs got %h/%h/%h expected all zero", rd_addr, wr_addr, w_wr_data);
        end
        checks++;
        if ({busy1, done1, rd_en1, w_wr_en1, grad_clr_en1, rd_addr1, wr_addr1, w_wr_data1} !== '0) begin
            errors++;
            $display("FAIL reset1 outputs got data %h expected all zero", w_wr_data1);
        end
        rst = 1'b0;
    endtask

    // Single-weight pass: write in cycle 3, done in cycle 4, idle in cycle 5.
    task automatic run1(input string nm, input logic [15:0] lv, input logic [15:0] gv,
                        input logic [15:0] wv, input logic [15:0] exp_d);
        logic [1:0] exp_bd;
        @(negedge clk);
        g1 = gv; w1 = wv; lr1 = lv; start1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            exp_bd = (c <= 3) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
            checks++;
            if ({busy1, done1} !== exp_bd) begin
                errors++;
                $display("FAIL %s busy/done cycle %0d got %b expected %b", nm, c, {busy1, done1}, exp_bd);
            end
            if (c == 3) begin
                checks++;
                if ({w_wr_en1, grad_clr_en1, wr_addr1} !== 3'b110) begin
                    errors++;
                    $display("FAIL %s strobes got %b expected 110", nm, {w_wr_en1, grad_clr_en1, wr_addr1});
                end
                checks++;
                if (w_wr_data1 !== exp_d) begin
                    errors++;
                    $display("FAIL %s w_wr_data got %h expected %h", nm, w_wr_data1, exp_d);
                end
            end
        end
    endtask

    task automatic test_values();
        clip_limit = 16'h0100;
        run1("basic",      16'h0080, 16'h0200, 16'h0100, 16'h0000);
        run1("pos_sat",    16'h0100, 16'hFF00, 16'h7F00, 16'h7FFF);
        run1("neg_sat",    16'h0100, 16'h0100, 16'h8000, 16'h8000);
        run1("trunc",      16'h0080, 16'hFFFF, 16'h0000, 16'h0001);
`ifdef GRAD_CLIP_EN
        run1("clip",       16'h0100, 16'h0400, 16'h0200, 16'h0100);
        clip_limit = 16'h0000;
        run1("clip_zero",  16'h0100, 16'hF000, 16'h0200, 16'h0200);
`else
        run1("clip_off",   16'h0100, 16'h0400, 16'h0200, 16'hFE00);
`endif
    endtask

    // 16-weight pass; trig>0 aborts (or resets) at that cycle, outputs idle afterwards.
    task automatic run_pass(input string nm, input int trig, input bit trig_rst,
                            input bit start2, input bit abort_with_start);
        logic [15:0] lr_v, clip_v, exp_d, exp_w, exp_g;
        int          i, ph;
        bit          stopped, e_busy, e_done, e_rd, e_wr, written;
        lr_v   = 16'($urandom_range(0, 510) - 255);
        clip_v = 16'($urandom_range(16, 2048));
        for (int k = 0; k < N; k++) begin
            init_w[k] = 16'($urandom);
            init_g[k] = 16'($urandom);
        end
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        clip_limit = clip_v; lr = lr_v; start = 1'b1; abort = abort_with_start;
        for (int c = 1; c <= 3*N + 3; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            stopped = (trig > 0) && (c > trig);
            e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; i = 0; ph = 0;
            if (!stopped) begin
                if (c <= 3*N) begin
                    i = (c - 1) / 3; ph = (c - 1) % 3;
                    e_busy = 1; e_rd = (ph == 0); e_wr = (ph == 2);
                end else if (c == 3*N + 1) begin
                    e_done = 1;
                end
            end
            checks++;
            if ({busy, done, rd_en, w_wr_en, grad_clr_en} !== {e_busy, e_done, e_rd, e_wr, e_wr}) begin
                errors++;
                $display("FAIL %s strobes cycle %0d got %b expected %b", nm, c,
                         {busy, done, rd_en, w_wr_en, grad_clr_en}, {e_busy, e_done, e_rd, e_wr, e_wr});
            end
            if (e_rd) begin
                checks++;
                if (rd_addr !== AW'(i)) begin
                    errors++;
                    $display("FAIL %s rd_addr cycle %0d got %0d expected %0d", nm, c, rd_addr, i);
                end
            end
            if (e_wr) begin
                exp_d = model_upd(init_w[i], init_g[i], lr_v, clip_v);
                checks++;
                if ({wr_addr, w_wr_data} !== {AW'(i), exp_d}) begin
                    errors++;
                    $display("FAIL %s write cycle %0d got addr %0d data %h expected addr %0d data %h",
                             nm, c, wr_addr, w_wr_data, i, exp_d);
                end
            end
            if (stopped && trig_rst) begin
                checks++;
                if ({rd_addr, wr_addr, w_wr_data} !== '0) begin
                    errors++;
                    $display("FAIL %s post-reset cycle %0d got %h/%h/%h expected zero",
                             nm, c, rd_addr, wr_addr, w_wr_data);
                end
            end
            if (trig_rst) rst = (c == trig);
            else          abort = (c == trig);
            if (start2 && c == 10) begin
                start = 1'b1;
                lr = 16'($urandom);
            end
        end
        for (int k = 0; k < N; k++) begin
            written = (trig == 0) || (3*k + 3 <= trig);
            exp_w = written ? model_upd(init_w[k], init_g[k], lr_v, clip_v) : init_w[k];
            exp_g = written ? 16'h0000 : init_g[k];
            checks++;
            if ({mem_w[k], mem_g[k]} !== {exp_w, exp_g}) begin
                errors++;
                $display("FAIL %s storage[%0d] got w %h g %h expected w %h g %h",
                         nm, k, mem_w[k], mem_g[k], exp_w, exp_g);
            end
        end
    endtask

    task automatic test_full_pass();
        run_pass("full_pass_start2", 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_start_beats_abort();
        run_pass("start_with_abort", 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        run_pass("abort_mul5",   3*5 + 2, 1'b0, 1'b0, 1'b0);
        run_pass("abort_read4",  3*4 + 1, 1'b0, 1'b0, 1'b0);
        run_pass("abort_write3", 3*3 + 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        run_pass("reset_write2", 3*2 + 3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++)
            run_pass("random_pass", 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_values();
        test_full_pass();
        test_start_beats_abort();
        test_abort();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
